// File: rtl/count_ctrl.sv
// Run/stop sequencer with prescaled step pulses and a round-robin arbiter
// that shares the tick counter's load port between two requesters.
module count_ctrl #(
    parameter int PRESCALE = 50_000_000,
    parameter int W        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] val0,
    input  logic [W-1:0] val1,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] cnt_in,
    output logic         gnt0,
    output logic         gnt1,
    output logic         ld,
    output logic [W-1:0] ld_val,
    output logic         step,
    output logic         running,
    output logic         done
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          rr, rr_nxt;
    logic          gnt0_nxt, gnt1_nxt, step_nxt, grant;
    logic [W-1:0]  ld_val_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            rr      <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ld      <= 1'b0;
            ld_val  <= '0;
            step    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            rr      <= rr_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            ld      <= grant;
            ld_val  <= ld_val_nxt;
            step    <= step_nxt;
            running <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        rr_nxt     = rr;
        gnt0_nxt   = 1'b0;
        gnt1_nxt   = 1'b0;
        ld_val_nxt = '0;
        step_nxt   = 1'b0;

        // A grant currently on the outputs forces one idle arbitration cycle.
        if (!(gnt0 || gnt1)) begin
            if (req0 && (!req1 || !rr)) begin
                gnt0_nxt   = 1'b1;
                ld_val_nxt = val0;
                rr_nxt     = 1'b1;
            end else if (req1) begin
                gnt1_nxt   = 1'b1;
                ld_val_nxt = val1;
                rr_nxt     = 1'b0;
            end
        end
        grant = gnt0_nxt | gnt1_nxt;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                end else if (grant) begin
                    // A load pre-empts a coinciding terminal tick and restarts the period.
                    presc_nxt = '0;
                end else if (presc == PTERM) begin
                    presc_nxt = '0;
                    if (cnt_in == limit) state_nxt = DONE;
                    else                 step_nxt  = 1'b1;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            DONE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a deadline-based model.
module tb_count_ctrl;

    localparam int P = 4;
    localparam int W = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic         clk = 1'b0, reset = 1'b0;
    logic         start = 1'b0, stop = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] val0 = '0, val1 = '0, limit = 4'd15, cnt;
    logic         gnt0, gnt1, ld, step, running, done;
    logic [W-1:0] ld_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_ctrl #(.PRESCALE(P), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .req0(req0), .req1(req1), .val0(val0), .val1(val1),
        .limit(limit), .cnt_in(cnt),
        .gnt0(gnt0), .gnt1(gnt1), .ld(ld), .ld_val(ld_val),
        .step(step), .running(running), .done(done)
    );

    // Stand-in for the counter datapath: loads on ld, increments on step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (ld)   cnt <= ld_val;
        else if (step) cnt <= cnt + 1'b1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the absolute cycle of the next terminal tick and
    // of the last grant instead of a prescaler register.
    int           cyc, mode, due, last_gnt, side;
    bit           prefer, granted;
    logic         exp_gnt0, exp_gnt1, exp_ld, exp_step, exp_running, exp_done;
    logic [W-1:0] exp_ld_val;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; mode = M_IDLE; due = 0; last_gnt = -10; prefer = 0;
            exp_gnt0 = 0; exp_gnt1 = 0; exp_ld = 0; exp_ld_val = '0;
            exp_step = 0; exp_running = 0; exp_done = 0;
        end else begin
            cyc++;
            exp_gnt0 = 0; exp_gnt1 = 0; exp_ld = 0; exp_step = 0;
            granted = 0;
            if (cyc != last_gnt + 1 && (req0 || req1)) begin
                side       = (req0 && req1) ? int'(prefer) : (req1 ? 1 : 0);
                granted    = 1;
                last_gnt   = cyc;
                prefer     = (side == 0);
                exp_gnt0   = (side == 0);
                exp_gnt1   = (side == 1);
                exp_ld     = 1;
                exp_ld_val = (side == 1) ? val1 : val0;
            end
            if (stop) mode = M_IDLE;
            else if (mode != M_RUN) begin
                if (start) begin mode = M_RUN; due = cyc + P; end
            end else if (granted) due = cyc + P;
            else if (cyc == due) begin
                if (cnt == limit) mode = M_DONE;
                else begin exp_step = 1; due = cyc + P; end
            end
            exp_running = (mode == M_RUN);
            exp_done    = (mode == M_DONE);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("model gnt0", gnt0, exp_gnt0);
            checkOutput("model gnt1", gnt1, exp_gnt1);
            checkOutput("model ld", ld, exp_ld);
            if (exp_ld) checkOutput("model ld_val", ld_val, exp_ld_val);
            checkOutput("model step", step, exp_step);
            checkOutput("model running", running, exp_running);
            checkOutput("model done", done, exp_done);
        end
    end

    typedef struct {
        logic         start, stop, req0, req1;
        logic [W-1:0] val0, val1;
        logic         g0, g1, ld, stp, run, dn;
        logic [W-1:0] ldv;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t make_vec(input int s, st, r0, r1, v0, v1,
                                      g0, g1, l, lv, sp, rn, dn);
        vec_t v;
        v.start = 1'(s);  v.stop = 1'(st); v.req0 = 1'(r0); v.req1 = 1'(r1);
        v.val0 = 4'(v0);  v.val1 = 4'(v1);
        v.g0 = 1'(g0); v.g1 = 1'(g1); v.ld = 1'(l); v.ldv = 4'(lv);
        v.stp = 1'(sp); v.run = 1'(rn); v.dn = 1'(dn);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start = v.start; stop = v.stop; req0 = v.req0; req1 = v.req1;
        val0 = v.val0;   val1 = v.val1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //                 st sp r0 r1 v0 v1  g0 g1 ld ldv stp run dn
        tbl[0]  = make_vec(0, 0, 1, 1, 5, 9,  1, 0, 1, 5, 0, 0, 0);
        tbl[1]  = make_vec(0, 0, 0, 1, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = make_vec(0, 0, 0, 1, 5, 9,  0, 1, 1, 9, 0, 0, 0);
        tbl[3]  = make_vec(0, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = make_vec(0, 0, 1, 1, 5, 9,  1, 0, 1, 5, 0, 0, 0);
        tbl[5]  = make_vec(0, 0, 0, 1, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = make_vec(0, 0, 0, 1, 5, 9,  0, 1, 1, 9, 0, 0, 0);
        tbl[7]  = make_vec(0, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = make_vec(1, 1, 0, 0, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = make_vec(1, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0, 1, 0);
        tbl[10] = make_vec(1, 1, 0, 0, 5, 9,  0, 0, 0, 0, 0, 0, 0);
        tbl[11] = make_vec(0, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {gnt0, gnt1, ld, step, running, done}, 0);
        checkOutput("reset ld_val", ld_val, 0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cycle();
            checkOutput("idle outputs", {gnt0, gnt1, ld, step, running, done}, 0);
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d gnt0", i), gnt0, tbl[i].g0);
            checkOutput($sformatf("vec%0d gnt1", i), gnt1, tbl[i].g1);
            checkOutput($sformatf("vec%0d ld", i), ld, tbl[i].ld);
            if (tbl[i].ld) checkOutput($sformatf("vec%0d ld_val", i), ld_val, tbl[i].ldv);
            checkOutput($sformatf("vec%0d step", i), step, tbl[i].stp);
            checkOutput($sformatf("vec%0d running", i), running, tbl[i].run);
            checkOutput($sformatf("vec%0d done", i), done, tbl[i].dn);
        end

        // Run to limit 3 from a loaded 0.
        limit = 4'd3; req0 = 1'b1; val0 = 4'd0;
        cycle();
        req0 = 1'b0;
        checkOutput("limit load", {ld, ld_val}, {1'b1, 4'd0});
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checkOutput("limit running", running, 1);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            checkOutput($sformatf("limit step k=%0d", k), step, int'(k % 4 == 0 && k < 16));
        end
        checkOutput("limit done", done, 1);
        checkOutput("limit running end", running, 0);
        checkOutput("limit cnt", cnt, 3);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checkOutput("limit stop done", done, 0);

        // Load grant landing on the terminal prescale cycle.
        limit = 4'd15; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            if (k == 3) begin req0 = 1'b1; val0 = 4'd2; end
            if (k == 4) begin
                checkOutput("collide ld", ld, 1);
                checkOutput("collide ld_val", ld_val, 2);
                req0 = 1'b0;
            end
            checkOutput($sformatf("collide step k=%0d", k), step, int'(k == 8));
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Asynchronous reset between edges while running.
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        checkOutput("pre-reset running", running, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkOutput("async reset running", running, 0);
        checkOutput("async reset outputs", {gnt0, gnt1, ld, step, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checkOutput($sformatf("post-reset step k=%0d", k), step, int'(k == 4));
        end

        // Random traffic; requesters hold req until they see their grant.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            if (req0 && gnt0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 5) == 0) begin req0 = 1'b1; val0 = 4'($urandom); end
            if (req1 && gnt1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 5) == 0) begin req1 = 1'b1; val1 = 4'($urandom); end
            if ($urandom_range(0, 199) == 0) limit = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
